// File: rtl/nonce_tx_queue.sv
// nonce_tx_queue: buffers golden nonces from the hasher chain and hands them
// one at a time to serial_transmit over a send/busy handshake.
// A toggle on load_flag (new work loaded) flushes queued, now stale, nonces.
// Optional build macro NONCE_DEDUP_EN: silently discards a nonce equal to the
// most recently reported one (hasher chains may report the same nonce twice).
module nonce_tx_queue #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           nonce_in,
    input  logic                  nonce_valid,
    input  logic                  load_flag,
    input  logic                  tx_busy,
    output logic                  tx_send,
    output logic [31:0]           tx_word,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic [7:0]            overflow_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

    // Storage and pointers
    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_addr_s;
    logic [LVL_W-1:0] level_q, level_d;
    logic             empty_q, empty_d;
    logic [7:0]       overflow_q, overflow_d;
    logic             load_flag_q;

    // Transmit FSM
    state_e           state_q;
    logic             tx_send_q;
    logic [31:0]      tx_word_q;
    logic [1:0]       ack_cnt_q;

    // Control strobes
    logic flush_s, full_s, pop_s, dup_s, req_s, push_s, drop_s;

    assign flush_s = load_flag ^ load_flag_q;
    assign full_s  = (level_q == LVL_FULL);
    // A launch dequeues the head in the same edge the FSM leaves IDLE.
    assign pop_s   = (state_q == ST_IDLE) && !empty_q && !tx_busy;

`ifdef NONCE_DEDUP_EN
    logic [31:0] last_nonce_q;
    logic        last_valid_q;

    // A flush forgets the last nonce, so the first nonce of new work is never a duplicate.
    assign dup_s = nonce_valid && last_valid_q && !flush_s && (nonce_in == last_nonce_q);

    // Remember the most recent non-duplicate nonce, whether it was queued or dropped full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_nonce_q <= 32'd0;
            last_valid_q <= 1'b0;
        end else if (req_s) begin
            last_nonce_q <= nonce_in;
            last_valid_q <= 1'b1;
        end else if (flush_s) begin
            last_valid_q <= 1'b0;
        end else begin
            last_valid_q <= last_valid_q;
        end
    end
`else
    assign dup_s = 1'b0;
`endif

    // Flush empties the queue first, so a coinciding nonce always fits.
    assign req_s  = nonce_valid && !dup_s;
    assign push_s = req_s && (flush_s || !full_s || pop_s);
    assign drop_s = req_s && !flush_s && full_s && !pop_s;

    // Next-state computation for pointers, occupancy and the drop counter.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_addr_s  = wr_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (flush_s) begin
            rd_ptr_d  = PTR_ZERO;
            wr_addr_s = PTR_ZERO;
            if (push_s) begin
                wr_ptr_d = PTR_ONE;
                level_d  = LVL_ONE;
            end else begin
                wr_ptr_d = PTR_ZERO;
                level_d  = LVL_ZERO;
            end
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end

        if (drop_s && (overflow_q != 8'hFF)) begin
            overflow_d = overflow_q + 8'd1;
        end else begin
            overflow_d = overflow_q;
        end

        empty_d = (level_d == LVL_ZERO);
    end

    // Queue bookkeeping registers and the load_flag edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            level_q     <= LVL_ZERO;
            empty_q     <= 1'b1;
            overflow_q  <= 8'd0;
            load_flag_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            load_flag_q <= load_flag;
        end
    end

    // Nonce storage; written only on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (push_s) begin
            mem_q[wr_addr_s] <= nonce_in;
        end else begin
            mem_q[wr_addr_s] <= mem_q[wr_addr_s];
        end
    end

    // Transmit handshake: launch head, strobe send once, await busy rise then fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tx_send_q <= 1'b0;
            tx_word_q <= 32'd0;
            ack_cnt_q <= 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        state_q   <= ST_SEND;
                        tx_send_q <= 1'b1;
                        tx_word_q <= mem_q[rd_ptr_q];
                    end else begin
                        tx_send_q <= 1'b0;
                    end
                end
                ST_SEND: begin
                    tx_send_q <= 1'b0;
                    ack_cnt_q <= 2'd0;
                    state_q   <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    tx_send_q <= 1'b0;
                    if (tx_busy) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (ack_cnt_q == 2'd3) begin
                        // No acknowledge within four cycles: the word is lost.
                        state_q <= ST_IDLE;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + 2'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    tx_send_q <= 1'b0;
                    if (!tx_busy) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_WAIT_DONE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    tx_send_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_send      = tx_send_q;
    assign tx_word      = tx_word_q;
    assign level        = level_q;
    assign empty        = empty_q;
    assign overflow_cnt = overflow_q;

endmodule

// File: doc/nonce_tx_queue.md
Name: nonce_tx_queue

Overview:
- Buffers golden nonces reported by the hasher chain and feeds them one at a time to serial_transmit (32-bit word, send/busy handshake).
- Decouples bursty nonce discovery from the slow UART byte stream.
- Flushes stale results when serial_receive signals new work via its load_flag toggle.
- Sits between hasher result output and serial_transmit.

Parameters:
DEPTH_LOG2, 3, log2 of queue depth; 3 gives 8 entries.

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
nonce_in  input  32  golden nonce from hasher
nonce_valid  input  1  single-cycle strobe; nonce_in valid this cycle
load_flag  input  1  serial_receive load_flag; each toggle means new work loaded
tx_busy  input  1  busy from serial_transmit
tx_send  output  1  send strobe to serial_transmit
tx_word  output  32  word to serial_transmit
level  output  DEPTH_LOG2+1  current queue occupancy
empty  output  1  level == 0
overflow_cnt  output  8  nonces dropped because the queue was full; saturates at 255

Behaviour:
- Reset values: tx_send=0, tx_word=0, level=0, empty=1, overflow_cnt=0, FSM=IDLE, load_flag_d=0.
- Reset mid-transmission abandons the queue; serial_transmit finishes its word independently.
- Queue:
  - Circular buffer, 2^DEPTH_LOG2 x 32 bits, with read/write pointers of DEPTH_LOG2 bits that wrap naturally.
  - Push on nonce_valid when not full.
  - Push while full with no pop in the same cycle: drop the nonce, overflow_cnt+1 (saturating).
  - Push and pop in the same cycle while full: both succeed, level unchanged.
- Flush:
  - flush = load_flag ^ load_flag_d, with load_flag_d registered every cycle.
  - On flush: pointers reset and level=0 next cycle; overflow_cnt is not cleared.
  - Flush in the same cycle as nonce_valid: queue cleared, then the incoming nonce is written as the sole entry (level=1).
  - Flush in the same cycle as a pop: the pop's word is still launched; the queue ends empty, or holds only the new nonce if nonce_valid is also high.
  - A word already launched is never aborted.
- Transmit FSM:
  - IDLE: when !empty && !tx_busy, go to SEND. In the same edge, register tx_word <= head and pop (level-1 unless a push coincides).
  - SEND: tx_send=1 for exactly this one cycle; tx_word stable. Go to WAIT_ACK.
  - WAIT_ACK: tx_send=0. Wait for tx_busy=1, then go to WAIT_DONE. serial_transmit raises busy the cycle after accepting send. If busy is not seen within 4 cycles, return to IDLE; the word is considered lost.
  - WAIT_DONE: wait for tx_busy=0, then go to IDLE.
  - tx_word holds its value until the next launch.
- Latency:
  - Nonce into an empty queue with the transmitter idle: tx_send asserts 2 cycles after the nonce_valid edge (push edge -> IDLE sees !empty -> SEND).
  - Back-to-back words: at least 1 IDLE cycle between tx_busy falling and the next tx_send.
- level and empty are registered and reflect the post-edge state.

Optional Feature:
NONCE_DEDUP_EN
- Defined:
  - Keeps last_nonce plus a last_valid bit; last_valid is cleared on reset and on flush.
  - A nonce_valid whose nonce_in equals last_nonce while last_valid=1 is discarded silently: no push, no overflow count.
  - Every accepted or dropped-full nonce updates last_nonce and sets last_valid.
  - Guards against hasher chains reporting the same nonce twice.
- Undefined: no comparison logic; every nonce_valid is treated as above.

Test Plan:
- After reset, single nonce 0xDEADBEEF with tx_busy=0 -> tx_send high exactly 1 cycle, 2 cycles after the strobe, tx_word=0xDEADBEEF; model busy for 40 cycles -> no second send; level returns to 0.
- 10 strobes (0x1..0xA) on consecutive cycles, DEPTH_LOG2=3, transmitter busy -> 8 queued, overflow_cnt=2; drained in order 0x1..0x8, one send per busy-low window.
- Push and pop in the same cycle with queue full -> level stays 8, overflow_cnt unchanged, order preserved.
- Queue holds 5 entries, toggle load_flag while word 0x3 is in flight -> serial word 0x3 completes; level=0 next cycle, no further sends. Repeat with nonce_valid=0x77 in the flush cycle -> only 0x77 sent afterwards.
- tx_busy held 0 after send (no ack) -> FSM returns to IDLE after 4 WAIT_ACK cycles and launches the next entry.
- NONCE_DEDUP_EN defined: strobes 0x55, 0x55, 0x56, 0x55 -> sends 0x55, 0x56, 0x55. Same stimulus with the macro undefined -> 4 sends.
